ram_requester: RTL and testbench
================================

# ram_requester

Request/response front-end that drives the single-port-pair register RAM (registered read, one write per cycle) on behalf of a client such as the CPU datapath or a loader. Accepts one read or write per cycle over a valid/ready request channel, drives the RAM's read address, write address, write data and write enable, captures the RAM's 1-cycle-late read result, and returns read data in order over a valid/ready response channel with a small FIFO for backpressure.

## Interface
- addr_size, default 4: RAM address width.
- cell_size, default 16: RAM data width.
- resp_depth, default 4: response FIFO entries; power of two, minimum 2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  client request present.
- req_ready  output  1  block accepts request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  addr_size  request address.
- req_data  input  cell_size  write data; ignored for reads.
- resp_valid  output  1  read data available.
- resp_ready  input  1  client consumes response this cycle.
- resp_data  output  cell_size  read data, in request order.
- ram_ra  output  addr_size  to RAM read address.
- ram_wa  output  addr_size  to RAM write address.
- ram_data  output  cell_size  to RAM write data.
- ram_we  output  1  to RAM write enable.
- ram_result  input  cell_size  from RAM registered read output.

## Operation
- Accept = req_valid & req_ready, one request per cycle maximum.
- ram_ra = ram_wa = req_addr, ram_data = req_data (combinational pass-through).
- ram_we = accept & req_we; 0 whenever rst is high.
- Write: completes at the accepting edge; produces no response.
- Read: accepted in cycle N sets rd_pending at end of N; ram_result valid in cycle N+1; pushed into FIFO at end of N+1.
- rd_pending: 1-bit flag; set by read accept, cleared otherwise (next-state = accept & ~req_we).
- Credit rule: req_ready = ~rst & (fifo_count + rd_pending < resp_depth). req_ready does not depend on req_valid or req_we. Same-cycle pop does not free a credit.
- FIFO: circular buffer, wr/rd pointers wrap at resp_depth; count 0..resp_depth. Push and pop in same cycle: count unchanged, both pointers advance. Push when full never occurs by credit rule (assertion).
- resp_valid = fifo_count != 0; resp_data = head entry when valid, 0 when empty.
- Ordering: responses strictly in read-accept order; interleaved writes do not reorder.
- Read-after-write to same address in consecutive cycles returns new data (write lands at the accept edge, read samples on the following edge).
- rst: clears rd_pending, pointers, count; forces req_ready=0, ram_we=0, resp_valid=0, resp_data=0. A ram_result arriving in the cycle after reset is discarded (rd_pending already 0). Storage contents need not clear.

## Timing
- Reset values: req_ready 0 (during rst), resp_valid 0, resp_data 0, ram_we 0, rd_pending 0, fifo_count 0.
- First cycle after rst deasserts: req_ready 1.
- Read latency: accept in cycle N -> resp_valid in cycle N+2 (FIFO empty, no backpressure).
- Throughput: one read per cycle sustained when resp_ready held high (steady state fifo_count 1, rd_pending 1).
- Backpressure: with resp_ready low, at most resp_depth reads outstanding; req_ready drops in the cycle fifo_count + rd_pending reaches resp_depth; reads in flight always have a FIFO slot.
- Writes blocked by the same req_ready even though they need no slot (simplifies the ready rule).

## Test plan
- Reset: hold rst 3 cycles with req_valid=1, req_we=1 -> ram_we=0, req_ready=0, resp_valid=0 throughout; first post-reset cycle req_ready=1.
- Write then read: write 0xBEEF to addr 3 in cycle N, read addr 3 in N+1 -> resp_valid in N+3 with resp_data=0xBEEF.
- Streaming: 16 back-to-back reads of addr 0..15 (preloaded with addr*0x0101), resp_ready=1 -> 16 responses on consecutive cycles, in order, req_ready never drops.
- Backpressure: resp_ready=0, issue reads continuously -> exactly 4 accepted, req_ready 0 thereafter; raise resp_ready -> 4 responses in order, then acceptance resumes, no loss or duplication.
- Mixed traffic: random read/write mix, random resp_ready, 2000 cycles -> every read response matches shadow memory at accept time; FIFO never overflows.
- Reset mid-operation: rst for 1 cycle with 3 responses queued and a read pending -> resp_valid 0 next cycle, stale ram_result not pushed, subsequent reads return correct data.

Source files
------------

// File: rtl/ram_requester.sv
// ram_requester: valid/ready front-end for the register RAM.
// Requests pass straight through to the RAM ports; read results come back
// one cycle late from the RAM and are queued in a small response FIFO so
// the client can apply backpressure without losing data.
module ram_requester #(
  parameter int addr_size  = 4,
  parameter int cell_size  = 16,
  parameter int resp_depth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [addr_size-1:0] req_addr,
  input  logic [cell_size-1:0] req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [cell_size-1:0] resp_data,
  output logic [addr_size-1:0] ram_ra,
  output logic [addr_size-1:0] ram_wa,
  output logic [cell_size-1:0] ram_data,
  output logic                 ram_we,
  input  logic [cell_size-1:0] ram_result
);

  localparam int ptr_w = $clog2(resp_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(resp_depth);

  logic [cell_size-1:0] fifo_mem [resp_depth];
  logic [ptr_w-1:0]     wr_ptr;
  logic [ptr_w-1:0]     rd_ptr;
  logic [cnt_w-1:0]     fifo_count;
  logic                 rd_pending;

  logic [cnt_w-1:0]     used;
  logic                 accept;
  logic                 push;
  logic                 pop;

  // Request side: credit check and combinational RAM port drive.
  // A read in flight already owns a slot, so it is counted with the FIFO
  // contents; a pop in the same cycle deliberately does not return a credit.
  always_comb begin
    used      = fifo_count + cnt_w'(rd_pending);
    req_ready = ~rst & (used < depth_c);
    accept    = req_valid & req_ready;
    ram_we    = accept & req_we;
    ram_ra    = req_addr;
    ram_wa    = req_addr;
    ram_data  = req_data;
  end

  // Response side: head of FIFO presented to the client, zero when empty.
  always_comb begin
    resp_valid = ~rst & (fifo_count != '0);
    resp_data  = resp_valid ? fifo_mem[rd_ptr] : '0;
    pop        = resp_valid & resp_ready;
    push       = rd_pending & ~rst;
  end

  // Control state: pending-read flag, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      rd_pending <= accept & ~req_we;
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + cnt_w'(1);
        2'b01:   fifo_count <= fifo_count - cnt_w'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage: captures the RAM's late read result; contents survive reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= ram_result;
    end
  end

  // The credit rule guarantees an in-flight read always finds a free slot.
  assert property (@(posedge clk) disable iff (rst) !(push && fifo_count == depth_c));

endmodule

// File: tb/tb_ram_requester.sv
// Bench for ram_requester: behavioural RAM, shadow-memory reference model,
// scoreboard queue of expected read data and an independent response monitor.
module tb_ram_requester;

  localparam int AW    = 4;
  localparam int CW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [CW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [CW-1:0] resp_data;
  logic [AW-1:0] ram_ra;
  logic [AW-1:0] ram_wa;
  logic [CW-1:0] ram_data;
  logic          ram_we;
  logic [CW-1:0] ram_result;

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] ram_mem [1<<AW];
  logic [CW-1:0] shadow  [1<<AW];
  logic [CW-1:0] sb [$];
  int            outstanding = 0;
  bit            prev_rd     = 1'b0;

  ram_requester #(.addr_size(AW), .cell_size(CW), .resp_depth(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .ram_ra(ram_ra), .ram_wa(ram_wa), .ram_data(ram_data), .ram_we(ram_we),
    .ram_result(ram_result)
  );

  always #5 clk = ~clk;

  // Register RAM: write and registered read on the same edge, read sees old data.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_wa] <= ram_data;
    ram_result <= ram_mem[ram_ra];
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: credits from outstanding reads, shadow memory updated at
  // accept time, expected read data pushed to the scoreboard on read accept.
  initial begin
    bit exp_ready, exp_rv, acc, mpop;
    forever begin
      @(negedge clk);
      exp_ready = !rst && (outstanding < DEPTH);
      exp_rv    = !rst && ((outstanding - int'(prev_rd)) > 0);
      acc       = req_valid && exp_ready;
      chk("req_ready", req_ready, exp_ready);
      chk("ram_we", ram_we, acc && req_we);
      chk("ram_ra", ram_ra, req_addr);
      chk("ram_wa", ram_wa, req_addr);
      chk("ram_data", ram_data, req_data);
      chk("resp_valid", resp_valid, exp_rv);
      if (rst) begin
        sb.delete();
        outstanding = 0;
        prev_rd     = 1'b0;
      end else begin
        mpop = exp_rv && resp_ready;
        if (acc && req_we)  shadow[req_addr] = req_data;
        if (acc && !req_we) sb.push_back(shadow[req_addr]);
        outstanding = outstanding + int'(acc && !req_we) - int'(mpop);
        prev_rd     = acc && !req_we;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT hands over a response.
  initial begin
    logic [CW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_resp", 64'(resp_data), 64'hDEAD_0000_0000_0000);
          end else begin
            e = sb.pop_front();
            chk("resp_data", resp_data, e);
          end
        end else if (!resp_valid) begin
          chk("resp_data_empty", resp_data, '0);
        end
      end
    end
  end

  task automatic step(bit r, bit v, bit we, int a, int d, bit rr);
    @(posedge clk);
    #1;
    rst        = r;
    req_valid  = v;
    req_we     = we;
    req_addr   = AW'(a);
    req_data   = CW'(d);
    resp_ready = rr;
    @(negedge clk);
  endtask

  initial begin
    logic [19:0] vec;
    logic [19:0] want;
    int          nacc;
    bit          dropped;
    bit          resumed;

    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = '0;
      shadow[i]  = '0;
    end
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = '0;
    req_data = 16'h1234; resp_ready = 1'b1;

    // Reset held with a write request asserted
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 5, 16'h1234, 1);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("post_rst_ready", req_ready, 1'b1);

    // Write then read, latency of two cycles after read accept
    step(0, 1, 1, 3, 16'hBEEF, 1);
    step(0, 1, 0, 3, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("raw_not_yet", resp_valid, 1'b0);
    step(0, 0, 0, 0, 0, 1);
    chk("raw_valid", resp_valid, 1'b1);
    chk("raw_data", resp_data, 16'hBEEF);
    step(0, 0, 0, 0, 0, 1);

    // Streaming: preload, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) step(0, 1, 1, i, i * 16'h0101, 1);
    step(0, 0, 0, 0, 0, 1);
    dropped = 1'b0;
    vec     = '0;
    want    = '0;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) step(0, 1, 0, c, 0, 1);
      else        step(0, 0, 0, 0, 0, 1);
      vec[c] = resp_valid;
      if (c < 16 && !req_ready) dropped = 1'b1;
      if (c >= 2 && c < 18) want[c] = 1'b1;
    end
    chk("stream_ready_drop", dropped, 1'b0);
    chk("stream_valid_pattern", vec, want);

    // Backpressure: exactly DEPTH reads accepted while responses are held
    nacc = 0;
    for (int c = 0; c < 10; c++) begin
      step(0, 1, 0, $urandom_range(15), 0, 0);
      if (req_ready) nacc++;
    end
    chk("bp_accepts", nacc, DEPTH);
    chk("bp_ready_low", req_ready, 1'b0);
    resumed = 1'b0;
    for (int c = 0; c < 10 && !resumed; c++) begin
      step(0, 1, 0, $urandom_range(15), 0, 1);
      if (req_ready) resumed = 1'b1;
    end
    chk("bp_resumed", resumed, 1'b1);
    for (int c = 0; c < 8; c++) step(0, 0, 0, 0, 0, 1);

    // Reset with three responses queued and one read pending
    for (int c = 0; c < 4; c++) step(0, 1, 0, 5 + c, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    for (int c = 0; c < 4; c++) step(0, 1, 0, 5 + c, 0, 1);
    for (int c = 0; c < 6; c++) step(0, 0, 0, 0, 0, 1);

    // Mixed random traffic
    for (int c = 0; c < 2000; c++) begin
      step(0, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(15),
           $urandom_range(16'hFFFF), $urandom_range(3) != 0);
    end
    for (int c = 0; c < 10; c++) step(0, 0, 0, 0, 0, 1);
    #1;
    chk("drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
